// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and default widths for the cache arbiter.
//   arb_state_t : arbiter FSM states
//   arb_src_t   : requester identity (instruction cache / data cache)
//   LINE_W_DEF  : default cacheline width in bits
//   ADDR_W_DEF  : default byte address width
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_t;

endpackage

// File: rtl/arb_select.sv
// -----------------------------------------------------------------------------
// arb_select
// Combinational winner selection between the instruction and data caches.
//   i_req     in  : instruction cache has a pending request
//   d_req     in  : data cache has a pending request (read or write)
//   last_src  in  : requester served most recently
//   sel_valid out : at least one request pending
//   sel_src   out : winning requester
// On a tie the requester that was not served last wins. Tying last_src to
// SRC_I gives fixed priority to the data cache.
// -----------------------------------------------------------------------------
module arb_select
  import arb_pkg::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  arb_src_t last_src,
  output logic     sel_valid,
  output arb_src_t sel_src
);

  always_comb begin
    sel_valid = i_req | d_req;
    sel_src   = SRC_I;
    if (i_req && d_req) begin
      sel_src = (last_src == SRC_D) ? SRC_I : SRC_D;
    end else if (d_req) begin
      sel_src = SRC_D;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
// Arbitrates instruction-cache fills and data-cache fills/writebacks onto a
// single downstream line interface.
//   clk, rst                 : clock, asynchronous active-high reset
//   icache_read/address      : instruction fill request
//   icache_rdata/resp        : instruction fill data / completion pulse
//   dcache_read/write/address/wdata : data fill / writeback request
//   dcache_rdata/resp        : data fill data / completion pulse
//   mem_read/write/address/wdata    : downstream request (registered)
//   mem_rdata/resp           : downstream read data / completion pulse
// Build option: define ARB_RR_EN for round-robin tie breaking with a 1-bit
// last-served pointer; otherwise the data cache always wins a tie.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | sample requests, grant the winner on the next edge
// SERVE_I | downstream request for icache held until mem_resp
// SERVE_D | downstream request for dcache held until mem_resp
// DONE    | one quiet cycle; requests ignored while requesters deassert
// -----------------------------------------------------------------------------
module cache_arbiter
  import arb_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state, state_nxt;
  arb_src_t          last_src;
  arb_src_t          sel_src;
  logic              sel_valid;
  logic              grant;

  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              rd_q;
  logic              wr_q;

  arb_select u_select (
    .i_req     (icache_read),
    .d_req     (dcache_read | dcache_write),
    .last_src  (last_src),
    .sel_valid (sel_valid),
    .sel_src   (sel_src)
  );

  assign grant = (state == IDLE) && sel_valid;

`ifdef ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_src <= SRC_D;
    end else if (grant) begin
      last_src <= sel_src;
    end
  end
`else
  // Pretending icache was served last makes every tie go to dcache.
  assign last_src = SRC_I;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          state_nxt = (sel_src == SRC_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Winner's request is captured at grant; downstream outputs use only these.
  // A simultaneous dcache read+write is captured as a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (grant) begin
      if (sel_src == SRC_D) begin
        addr_q  <= dcache_address;
        wdata_q <= dcache_wdata;
        rd_q    <= ~dcache_write;
        wr_q    <= dcache_write;
      end else begin
        addr_q  <= icache_address;
        wdata_q <= '0;
        rd_q    <= 1'b1;
        wr_q    <= 1'b0;
      end
    end
  end

  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = addr_q;
    mem_wdata    = wdata_q;
    icache_resp  = 1'b0;
    icache_rdata = '0;
    dcache_resp  = 1'b0;
    dcache_rdata = '0;
    case (state)
      SERVE_I: begin
        mem_read  = rd_q;
        mem_write = wr_q;
        if (mem_resp) begin
          icache_resp  = 1'b1;
          icache_rdata = mem_rdata;
        end
      end
      SERVE_D: begin
        mem_read  = rd_q;
        mem_write = wr_q;
        if (mem_resp) begin
          dcache_resp  = 1'b1;
          dcache_rdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(dcache_read && dcache_write))
        else $warning("cache_arbiter: dcache_read and dcache_write both high, treated as write");
    end
  end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;
  import arb_pkg::*;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          icache_read = 1'b0;
  logic [AW-1:0] icache_address = '0;
  logic [LW-1:0] icache_rdata;
  logic          icache_resp;
  logic          dcache_read = 1'b0;
  logic          dcache_write = 1'b0;
  logic [AW-1:0] dcache_address = '0;
  logic [LW-1:0] dcache_wdata = '0;
  logic [LW-1:0] dcache_rdata;
  logic          dcache_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_address (dcache_address),
    .dcache_wdata   (dcache_wdata),
    .dcache_rdata   (dcache_rdata),
    .dcache_resp    (dcache_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [LW-1:0] pat_a5, pat_w1, pat_w2, pat_r1, pat_r2, pat_r3;
  arb_src_t      exp_src [4];

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_w1 = {8{32'hDEAD_BEEF}};
    pat_w2 = {8{32'h1234_5678}};
    pat_r1 = {8{32'h0BAD_F00D}};
    pat_r2 = {8{32'hCAFE_0001}};
    pat_r3 = {8{32'h5A5A_3C3C}};
`ifdef ARB_RR_EN
    exp_src = '{SRC_D, SRC_I, SRC_D, SRC_I};
`else
    exp_src = '{SRC_D, SRC_D, SRC_D, SRC_D};
`endif

    // reset state
    #2;
    chk("rst_state", LW'(dut.state), LW'(IDLE));
    chk("rst_mem_read", LW'(mem_read), '0);
    chk("rst_mem_write", LW'(mem_write), '0);
    chk("rst_mem_address", LW'(mem_address), '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_resp", LW'({icache_resp, dcache_resp}), '0);
    step(); step();
    rst = 1'b0;
    step();

    // lone icache fill, mem_resp five cycles after the request
    icache_read = 1'b1; icache_address = 32'h0000_0060;
    #1 chk("t1_no_early_read", LW'(mem_read), '0);
    step();
    chk("t1_grant_state", LW'(dut.state), LW'(SERVE_I));
    chk("t1_mem_read", LW'(mem_read), LW'(1));
    chk("t1_mem_write", LW'(mem_write), '0);
    chk("t1_mem_address", LW'(mem_address), LW'(32'h60));
    repeat (3) begin
      step();
      chk("t1_hold_read", LW'(mem_read), LW'(1));
      chk("t1_no_early_resp", LW'(icache_resp), '0);
    end
    step();
    mem_resp = 1'b1; mem_rdata = pat_a5;
    #1;
    chk("t1_icache_resp", LW'(icache_resp), LW'(1));
    chk("t1_icache_rdata", icache_rdata, pat_a5);
    chk("t1_dcache_resp", LW'(dcache_resp), '0);
    chk("t1_dcache_rdata", dcache_rdata, '0);
    step();
    mem_resp = 1'b0; icache_read = 1'b0;
    #1;
    chk("t1_done_state", LW'(dut.state), LW'(DONE));
    chk("t1_done_mem_read", LW'(mem_read), '0);
    chk("t1_done_resp", LW'(icache_resp), '0);
    step();
    chk("t1_idle_state", LW'(dut.state), LW'(IDLE));

    // simultaneous dcache write and icache read: dcache first
    dcache_write = 1'b1; dcache_address = 32'h0000_1000; dcache_wdata = pat_w1;
    icache_read = 1'b1; icache_address = 32'h0000_0080;
    #1;
    step();
    chk("t2_state_d", LW'(dut.state), LW'(SERVE_D));
    chk("t2_mem_write", LW'(mem_write), LW'(1));
    chk("t2_mem_read", LW'(mem_read), '0);
    chk("t2_mem_address", LW'(mem_address), LW'(32'h1000));
    chk("t2_mem_wdata", mem_wdata, pat_w1);
    step(); step();
    mem_resp = 1'b1; mem_rdata = pat_r1;
    #1;
    chk("t2_dcache_resp", LW'(dcache_resp), LW'(1));
    chk("t2_icache_resp", LW'(icache_resp), '0);
    chk("t2_icache_rdata", icache_rdata, '0);
    step();
    mem_resp = 1'b0; dcache_write = 1'b0;
    #1;
    chk("t2_done_state", LW'(dut.state), LW'(DONE));
    chk("t2_done_mem", LW'({mem_read, mem_write}), '0);
    step();
    chk("t2_idle_state", LW'(dut.state), LW'(IDLE));
    chk("t2_idle_mem_read", LW'(mem_read), '0);
    step();
    chk("t2_state_i", LW'(dut.state), LW'(SERVE_I));
    chk("t2_i_mem_read", LW'(mem_read), LW'(1));
    chk("t2_i_mem_address", LW'(mem_address), LW'(32'h80));
    chk("t2_i_mem_wdata", mem_wdata, '0);
    mem_resp = 1'b1; mem_rdata = pat_r2;
    #1;
    chk("t2_i_resp", LW'(icache_resp), LW'(1));
    chk("t2_i_rdata", icache_rdata, pat_r2);
    step();
    mem_resp = 1'b0; icache_read = 1'b0;
    #1;
    chk("t2_i_done", LW'(dut.state), LW'(DONE));
    step();

    // four simultaneous request pairs
    for (int i = 0; i < 4; i++) begin
      icache_read = 1'b1; icache_address = 32'h0000_0100 + 32'(i * 64);
      dcache_read = 1'b1; dcache_address = 32'h0000_8000 + 32'(i * 64);
      #1;
      step();
      chk($sformatf("t3_state_%0d", i), LW'(dut.state),
          LW'((exp_src[i] == SRC_D) ? SERVE_D : SERVE_I));
      chk($sformatf("t3_addr_%0d", i), LW'(mem_address),
          LW'((exp_src[i] == SRC_D) ? 32'h0000_8000 + 32'(i * 64) : 32'h0000_0100 + 32'(i * 64)));
      mem_resp = 1'b1; mem_rdata = pat_r3;
      #1;
      chk($sformatf("t3_resp_%0d", i), LW'({icache_resp, dcache_resp}),
          LW'((exp_src[i] == SRC_D) ? 2'b01 : 2'b10));
      step();
      mem_resp = 1'b0; icache_read = 1'b0; dcache_read = 1'b0;
      #1;
      chk($sformatf("t3_done_%0d", i), LW'(dut.state), LW'(DONE));
      step();
    end

    // reset two cycles into SERVE_D
    dcache_read = 1'b1; dcache_address = 32'h0000_2000;
    #1;
    step();
    chk("t4_state_d", LW'(dut.state), LW'(SERVE_D));
    step();
    mem_resp = 1'b1; mem_rdata = pat_r1;
    #1;
    rst = 1'b1;
    #1;
    chk("t4_rst_state", LW'(dut.state), LW'(IDLE));
    chk("t4_rst_mem", LW'({mem_read, mem_write}), '0);
    chk("t4_rst_addr", LW'(mem_address), '0);
    chk("t4_rst_resp", LW'(dcache_resp), '0);
    chk("t4_rst_rdata", dcache_rdata, '0);
    step();
    rst = 1'b0; mem_resp = 1'b0; dcache_read = 1'b0;
    #1;
    chk("t4_post_idle", LW'(dut.state), LW'(IDLE));
    icache_read = 1'b1; icache_address = 32'h0000_3000;
    #1;
    step();
    chk("t4_i_state", LW'(dut.state), LW'(SERVE_I));
    chk("t4_i_addr", LW'(mem_address), LW'(32'h3000));
    icache_read = 1'b0;
    step();
    chk("t4_i_hold_state", LW'(dut.state), LW'(SERVE_I));
    chk("t4_i_hold_read", LW'(mem_read), LW'(1));
    mem_resp = 1'b1; mem_rdata = pat_r3;
    #1;
    chk("t4_i_resp", LW'(icache_resp), LW'(1));
    chk("t4_i_rdata", icache_rdata, pat_r3);
    step();
    mem_resp = 1'b0;
    #1;
    chk("t4_i_done", LW'(dut.state), LW'(DONE));
    step();

    // stray mem_resp in IDLE
    mem_resp = 1'b1; mem_rdata = pat_r2;
    #1;
    chk("t5_stray_resp", LW'({icache_resp, dcache_resp}), '0);
    chk("t5_stray_rdata", icache_rdata | dcache_rdata, '0);
    step();
    mem_resp = 1'b0;
    #1;
    chk("t5_stray_state", LW'(dut.state), LW'(IDLE));
    chk("t5_stray_mem", LW'({mem_read, mem_write}), '0);

    // dcache read and write together: issued as a write
    dcache_read = 1'b1; dcache_write = 1'b1;
    dcache_address = 32'h0000_4000; dcache_wdata = pat_w2;
    #1;
    step();
    chk("t5_rw_write", LW'(mem_write), LW'(1));
    chk("t5_rw_read", LW'(mem_read), '0);
    chk("t5_rw_wdata", mem_wdata, pat_w2);
    chk("t5_rw_addr", LW'(mem_address), LW'(32'h4000));
    dcache_read = 1'b0; dcache_write = 1'b0;
    mem_resp = 1'b1;
    #1;
    chk("t5_rw_resp", LW'(dcache_resp), LW'(1));
    step();
    mem_resp = 1'b0;
    #1;
    chk("t5_rw_done", LW'(dut.state), LW'(DONE));
    step();
    chk("t5_rw_idle", LW'(dut.state), LW'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
